// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE control with branch, call/return and a small return stack.
// Optional return-address stack compiled in with `define PC_SEQ_STACK_EN; without it call acts as branch and ret is ignored.
module pc_sequencer #(
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 4,
    parameter int START_ADDR  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            halt,
    input  logic            branch_en,
    input  logic            call_en,
    input  logic            ret_en,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic            running,
    output logic            done,
    output logic            fault
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    if (STACK_DEPTH < 1 || STACK_DEPTH > 16) begin : g_bad_depth
        $error("pc_sequencer: STACK_DEPTH must be in 1..16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pc_inc;
    logic            stk_fault;

    assign pc_inc = pc_q + PC_W'(1);

`ifdef PC_SEQ_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [PC_W-1:0]  stack_q [STACK_DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d, sp_dec;
    logic [IDX_W-1:0] push_idx, pop_idx;
    logic             fault_q, fault_d;
    logic             push_en;

    assign sp_dec   = sp_q - SP_W'(1);
    assign push_idx = sp_q[IDX_W-1:0];
    assign pop_idx  = sp_dec[IDX_W-1:0];

    // Return has priority over call, so a simultaneous pair faults only on underflow.
    assign stk_fault = ret_en ? (sp_q == '0) : (call_en && (sp_q == SP_FULL));
    assign fault     = fault_q;

    // Entries are never read before being pushed, so they carry no reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            fault_q <= fault_d;
        end
    end
`else
    logic unused_ret;

    assign unused_ret = ret_en;
    assign stk_fault  = 1'b0;
    assign fault      = 1'b0;
`endif

    // State register, also holding the registered status decodes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            pc_q      <= START_PC;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            done_q    <= done_d;
            pc_q      <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (halt || stk_fault) state_d = S_DONE;
            S_DONE:  if (!start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        running_d = (state_d == S_RUN);
        done_d    = (state_d == S_DONE);
    end

    always_comb begin
        pc_d = pc_q;
`ifdef PC_SEQ_STACK_EN
        sp_d    = sp_q;
        fault_d = fault_q;
        push_en = 1'b0;
`endif
        if (state_q == S_IDLE && start) begin
            pc_d = START_PC;
`ifdef PC_SEQ_STACK_EN
            sp_d    = '0;
            fault_d = 1'b0;
`endif
        end else if (state_q == S_RUN && !halt) begin
`ifdef PC_SEQ_STACK_EN
            if (ret_en) begin
                if (sp_q == '0) begin
                    fault_d = 1'b1;
                end else begin
                    sp_d = sp_dec;
                    pc_d = stack_q[pop_idx];
                end
            end else if (call_en) begin
                if (sp_q == SP_FULL) begin
                    fault_d = 1'b1;
                end else begin
                    push_en = 1'b1;
                    sp_d    = sp_q + SP_W'(1);
                    pc_d    = target;
                end
            end else if (branch_en) begin
                pc_d = target;
            end else begin
                pc_d = pc_inc;
            end
`else
            if (call_en || branch_en) begin
                pc_d = target;
            end else begin
                pc_d = pc_inc;
            end
`endif
        end
    end

    assign pc      = pc_q;
    assign running = running_q;
    assign done    = done_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a queue-based program-flow model.
module tb_pc_sequencer;
    localparam int PC_W  = 10;
    localparam int DEPTH = 4;
    localparam int START = 0;
    localparam int MOD   = 1 << PC_W;

    logic            clk = 1'b0;
    logic            reset, start, halt, branch_en, call_en, ret_en;
    logic [PC_W-1:0] target, pc;
    logic            running, done, fault;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.PC_W(PC_W), .STACK_DEPTH(DEPTH), .START_ADDR(START)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt),
        .branch_en(branch_en), .call_en(call_en), .ret_en(ret_en),
        .target(target), .pc(pc), .running(running), .done(done), .fault(fault)
    );

    // Model: 0 = idle, 1 = run, 2 = done; return addresses in a queue.
    int m_state;
    int m_pc;
    bit m_fault;
    int m_stack[$];

    function automatic void model_reset();
        m_state = 0; m_pc = START; m_fault = 0; m_stack.delete();
    endfunction

    function automatic void model_step();
        case (m_state)
            0: if (start) begin
                m_state = 1; m_pc = START; m_fault = 0; m_stack.delete();
            end
            1: begin
                if (halt) m_state = 2;
`ifdef PC_SEQ_STACK_EN
                else if (ret_en) begin
                    if (m_stack.size() == 0) begin m_fault = 1; m_state = 2; end
                    else m_pc = m_stack.pop_back();
                end else if (call_en) begin
                    if (m_stack.size() == DEPTH) begin m_fault = 1; m_state = 2; end
                    else begin m_stack.push_back((m_pc + 1) % MOD); m_pc = int'(target); end
                end else if (branch_en) m_pc = int'(target);
`else
                else if (call_en || branch_en) m_pc = int'(target);
`endif
                else m_pc = (m_pc + 1) % MOD;
            end
            default: if (!start) m_state = 0;
        endcase
    endfunction

    function automatic logic [PC_W+2:0] exp_out();
        return {PC_W'(m_pc), m_state == 1, m_state == 2, m_fault};
    endfunction

    task automatic clear_inputs();
        start = 0; halt = 0; branch_en = 0; call_en = 0; ret_en = 0; target = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset(); else model_step();
        #1;
    endtask

    task automatic fresh_run();
        clear_inputs();
        reset = 1; tick(); reset = 0;
        start = 1; tick(); start = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1; model_reset(); #2;
        n_vec++;
        if ({pc, running, done, fault} !== {PC_W'(START), 3'b000}) begin
            n_err++; $display("FAIL reset: got %h want %h", {pc, running, done, fault}, {PC_W'(START), 3'b000});
        end
        reset = 0;
        tick();
        n_vec++;
        if ({pc, running, done, fault} !== exp_out()) begin
            n_err++; $display("FAIL reset_idle: got %h want %h", {pc, running, done, fault}, exp_out());
        end
    endtask

    task automatic test_sequential();
        clear_inputs();
        start = 1; tick(); start = 0;
        for (int i = 0; i < 6; i++) begin
            n_vec++;
            if ({pc, running, done} !== {PC_W'(START + i), 2'b10} || {pc, running, done, fault} !== exp_out()) begin
                n_err++; $display("FAIL sequential[%0d]: got %h want %h", i, {pc, running, done, fault}, exp_out());
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        fresh_run();
        branch_en = 1; target = '1; tick(); branch_en = 0;
        tick();
        n_vec++;
        if ({pc, running, done, fault} !== {PC_W'(0), 3'b100} || {pc, running, done, fault} !== exp_out()) begin
            n_err++; $display("FAIL wrap: got %h want %h", {pc, running, done, fault}, exp_out());
        end
    endtask

    task automatic test_halt_call();
        fresh_run();
        tick();
        halt = 1; call_en = 1; target = 10'h055; tick(); halt = 0; call_en = 0;
        start = 1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({running, done} !== 2'b01 || {pc, running, done, fault} !== exp_out()) begin
                n_err++; $display("FAIL halt_hold[%0d]: got %h want %h", i, {pc, running, done, fault}, exp_out());
            end
            tick();
        end
        start = 0; tick();
        n_vec++;
        if ({running, done} !== 2'b00 || {pc, running, done, fault} !== exp_out()) begin
            n_err++; $display("FAIL done_to_idle: got %h want %h", {pc, running, done, fault}, exp_out());
        end
        start = 1; tick(); start = 0;
        n_vec++;
        if ({pc, running, done} !== {PC_W'(START), 2'b10} || {pc, running, done, fault} !== exp_out()) begin
            n_err++; $display("FAIL rerun: got %h want %h", {pc, running, done, fault}, exp_out());
        end
    endtask

`ifdef PC_SEQ_STACK_EN
    task automatic test_call_ret();
        fresh_run();
        tick(); tick(); tick();
        call_en = 1; target = 10'h040; tick(); call_en = 0;
        tick();
        ret_en = 1; tick(); ret_en = 0;
        n_vec++;
        if ({pc, running, done, fault} !== {PC_W'(4), 3'b100} || {pc, running, done, fault} !== exp_out()) begin
            n_err++; $display("FAIL call_ret: got %h want %h", {pc, running, done, fault}, exp_out());
        end
        ret_en = 1; tick(); ret_en = 0;
        n_vec++;
        if ({running, done, fault} !== 3'b011 || {pc, running, done, fault} !== exp_out()) begin
            n_err++; $display("FAIL sp_back_to_zero: got %h want %h", {pc, running, done, fault}, exp_out());
        end
    endtask

    task automatic test_overflow();
        fresh_run();
        for (int i = 0; i < DEPTH + 1; i++) begin
            call_en = 1; target = PC_W'(16 * (i + 1)); tick();
            n_vec++;
            if ({pc, running, done, fault} !== exp_out()) begin
                n_err++; $display("FAIL overflow[%0d]: got %h want %h", i, {pc, running, done, fault}, exp_out());
            end
        end
        call_en = 0;
        n_vec++;
        if ({pc, done, fault} !== {PC_W'(16 * DEPTH), 2'b11}) begin
            n_err++; $display("FAIL overflow_final: got %h want %h", {pc, done, fault}, {PC_W'(16 * DEPTH), 2'b11});
        end
        fresh_run();
        ret_en = 1; call_en = 1; target = 10'h123; tick(); ret_en = 0; call_en = 0;
        n_vec++;
        if ({pc, running, done, fault} !== {PC_W'(START), 3'b011} || {pc, running, done, fault} !== exp_out()) begin
            n_err++; $display("FAIL underflow: got %h want %h", {pc, running, done, fault}, exp_out());
        end
    endtask

    task automatic test_async_reset();
        fresh_run();
        call_en = 1; target = 10'h100; tick(); target = 10'h200; tick(); call_en = 0;
        #2 reset = 1; model_reset(); #1;
        n_vec++;
        if ({pc, running, done, fault} !== {PC_W'(START), 3'b000}) begin
            n_err++; $display("FAIL async_reset: got %h want %h", {pc, running, done, fault}, {PC_W'(START), 3'b000});
        end
        #1 reset = 0;
        tick(); tick();
        n_vec++;
        if ({pc, running, done, fault} !== exp_out()) begin
            n_err++; $display("FAIL post_reset_idle: got %h want %h", {pc, running, done, fault}, exp_out());
        end
    endtask
`else
    task automatic test_no_stack();
        fresh_run();
        call_en = 1; target = 10'h020; tick(); call_en = 0;
        n_vec++;
        if ({pc, running, done, fault} !== {PC_W'(32), 3'b100} || {pc, running, done, fault} !== exp_out()) begin
            n_err++; $display("FAIL nostack_call: got %h want %h", {pc, running, done, fault}, exp_out());
        end
        ret_en = 1; tick(); ret_en = 0;
        n_vec++;
        if ({pc, running, done, fault} !== {PC_W'(33), 3'b100} || {pc, running, done, fault} !== exp_out()) begin
            n_err++; $display("FAIL nostack_ret: got %h want %h", {pc, running, done, fault}, exp_out());
        end
        #2 reset = 1; model_reset(); #1;
        n_vec++;
        if ({pc, running, done, fault} !== {PC_W'(START), 3'b000}) begin
            n_err++; $display("FAIL async_reset: got %h want %h", {pc, running, done, fault}, {PC_W'(START), 3'b000});
        end
        #1 reset = 0;
        tick();
    endtask
`endif

    task automatic test_random();
        fresh_run();
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            start     = ($urandom_range(0, 3) != 0) ? start : ~start;
            halt      = ($urandom_range(0, 39) == 0);
            branch_en = ($urandom_range(0, 5) == 0);
            call_en   = ($urandom_range(0, 6) == 0);
            ret_en    = ($urandom_range(0, 6) == 0);
            target    = PC_W'($urandom);
            tick();
            n_vec++;
            if ({pc, running, done, fault} !== exp_out()) begin
                n_err++; $display("FAIL random[%0d]: got %h want %h", i, {pc, running, done, fault}, exp_out());
            end
        end
        clear_inputs();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        #12;
        test_reset();
        test_sequential();
        test_wrap();
        test_halt_call();
`ifdef PC_SEQ_STACK_EN
        test_call_ret();
        test_overflow();
        test_async_reset();
`else
        test_no_stack();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
